id_ex_pipe: RTL and testbench
=============================

// Module: id_ex_pipe
// PURPOSE
//  ID->EX pipeline register with load-use hazard detection. Captures decoder fields, register-file
//  read data and the instruction PC on each accepted cycle. Inserts a bubble and stalls IF/ID when
//  the instruction in EX is a load whose rd feeds the instruction in ID.
//  Honours EX back-pressure and branch/jump flush, and counts inserted bubbles for performance checks.
// PARAMETERS
//  XLEN     32   data/PC width
//  CNT_W    16   width of the saturating bubble counter
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  rst            in   1      asynchronous, active-high reset
//  id_valid       in   1      ID holds a valid instruction
//  flush          in   1      branch/jump redirect from EX; kill ID and EX contents
//  ex_ready       in   1      EX can accept a new instruction this cycle
//  id_pc          in   XLEN   PC of the ID instruction
//  id_imm         in   32     sign-extended immediate
//  id_imm_en      in   1      immediate used
//  id_op          in   7      opcode
//  id_funct7      in   8      {1'b0,funct7}
//  id_funct3      in   3      funct3
//  id_rd_addr     in   5      destination register
//  id_rd_en       in   1      rd write enable
//  id_mem_op      in   5      {w_en,r_en,size[2:0]}; size 3'b111 = no memory access
//  id_jump_en     in   1      JAL/JALR/branch
//  id_rs1_addr    in   5      rs1 index
//  id_rs1_en      in   1      rs1 read (already 0 for x0)
//  id_rs2_addr    in   5      rs2 index
//  id_rs2_en      in   1      rs2 read
//  id_rs1_data    in   XLEN   rs1 value from register file
//  id_rs2_data    in   XLEN   rs2 value from register file
//  id_stall       out  1      hold PC and IF/ID this cycle (comb.)
//  ex_valid       out  1      EX register holds a real instruction
//  ex_pc, ex_imm, ex_imm_en, ex_op, ex_funct7, ex_funct3, ex_rd_addr, ex_rd_en, ex_mem_op,
//  ex_jump_en, ex_rs1_addr, ex_rs2_addr, ex_rs1_data, ex_rs2_data   out  registered copies
//  bubble_cnt     out  CNT_W  number of load-use bubbles inserted, saturating
// BEHAVIOUR
//  - Reset and bubble value: ex_valid=0, ex_rd_en=0, ex_jump_en=0, ex_imm_en=0, ex_mem_op=5'b00111,
//    all other ex_* = 0; bubble_cnt=0. Reset takes effect immediately and holds while rst=1.
//  - hazard = ex_valid & ex_mem_op[3] & ex_rd_en & (ex_rd_addr!=0) & id_valid &
//    ((id_rs1_en & id_rs1_addr==ex_rd_addr) | (id_rs2_en & id_rs2_addr==ex_rd_addr)).
//  - id_stall = ~flush & (hazard | ~ex_ready). This is combinational from the current EX state and inputs.
//  - Per-cycle update, evaluated in priority order:
//    1. flush: load bubble. A flush while ex_ready=0 still clears the register, and the count is unchanged.
//    2. ~ex_ready: hold all ex_* unchanged. No bubble is counted, even if hazard is set.
//    3. hazard: load bubble and increment bubble_cnt, stopping at all-ones.
//       The ID instruction stays in IF/ID and re-presents next cycle. hazard is then 0, so it is accepted.
//    4. id_valid: capture all id_* fields and set ex_valid=1, for a latency of 1 cycle.
//    5. otherwise: load bubble.
//  - A load-use pair therefore costs exactly 1 bubble. Back-to-back dependent loads cost 1 bubble each.
//  - A load to x0, or a store (r_en=0), never causes a hazard. Non-load RAW is left to forwarding.
//  - The data fields are captured as presented. This block does no forwarding.
// TESTING
//  - Reset: assert rst mid-run while ex_valid=1 -> same cycle ex_valid=0, ex_mem_op=5'b00111,
//    bubble_cnt=0.
//  - Streaming: ADDI x1,x0,5 then ADD x2,x1,x1 with ex_ready=1 -> each appears 1 cycle later,
//    id_stall=0 throughout, bubble_cnt=0.
//  - Load-use: LW x5,0(x2) (mem_op=5'b01010) followed by ADD x6,x5,x7 -> id_stall=1 for 1 cycle.
//    Then a bubble in EX, then ADD in EX; bubble_cnt=1.
//  - No false hazard: LW x0,... then ADD x1,x0,x0, and SW x5 then ADD x6,x5,x5 -> id_stall=0 and no bubbles.
//  - Back-pressure: hold ex_ready=0 for 3 cycles with a load-use pair pending -> ex_* stay stable
//    and id_stall=1; after release, exactly 1 bubble is inserted.
//  - Flush: flush=1 with ex_ready=0 and hazard=1 -> id_stall=0 and ex_valid=0 next cycle.
//    bubble_cnt is unchanged; the counter saturates at 16'hFFFF under forced repeated hazards.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with load-use hazard detection, flush and back-pressure handling,
// plus a saturating count of the load-use bubbles inserted.
module id_ex_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             flush,
    input  logic             ex_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [31:0]      id_imm,
    input  logic             id_imm_en,
    input  logic [6:0]       id_op,
    input  logic [7:0]       id_funct7,
    input  logic [2:0]       id_funct3,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_rd_en,
    input  logic [4:0]       id_mem_op,
    input  logic             id_jump_en,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs1_en,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs2_en,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [31:0]      ex_imm,
    output logic             ex_imm_en,
    output logic [6:0]       ex_op,
    output logic [7:0]       ex_funct7,
    output logic [2:0]       ex_funct3,
    output logic [4:0]       ex_rd_addr,
    output logic             ex_rd_en,
    output logic [4:0]       ex_mem_op,
    output logic             ex_jump_en,
    output logic [4:0]       ex_rs1_addr,
    output logic [4:0]       ex_rs2_addr,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [4:0]       MEM_NONE = 5'b00111;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        UPD_BUBBLE,
        UPD_HOLD,
        UPD_LOAD
    } upd_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic             vld_p1;
    logic [XLEN-1:0]  pc_p1;
    logic [31:0]      imm_p1;
    logic             imm_en_p1;
    logic [6:0]       op_p1;
    logic [7:0]       funct7_p1;
    logic [2:0]       funct3_p1;
    logic [4:0]       rd_addr_p1;
    logic             rd_en_p1;
    logic [4:0]       mem_op_p1;
    logic             jump_en_p1;
    logic [4:0]       rs1_addr_p1;
    logic [4:0]       rs2_addr_p1;
    logic [XLEN-1:0]  rs1_data_p1;
    logic [XLEN-1:0]  rs2_data_p1;
    logic [CNT_W-1:0] cnt;

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic cnt_inc;
    upd_e upd;

    // ID stage: hazard detection against the instruction currently held in EX
    always_comb begin
        ex_is_load = vld_p1 & mem_op_p1[3] & rd_en_p1 & (rd_addr_p1 != 5'd0);
        rs1_hit    = id_rs1_en & (id_rs1_addr == rd_addr_p1);
        rs2_hit    = id_rs2_en & (id_rs2_addr == rd_addr_p1);
        hazard     = ex_is_load & id_valid & (rs1_hit | rs2_hit);
        id_stall   = ~flush & (hazard | ~ex_ready);

        upd     = UPD_BUBBLE;
        cnt_inc = 1'b0;
        if (flush) begin
            upd = UPD_BUBBLE;
        end else if (!ex_ready) begin
            upd = UPD_HOLD;
        end else if (hazard) begin
            upd     = UPD_BUBBLE;
            cnt_inc = 1'b1;
        end else if (id_valid) begin
            upd = UPD_LOAD;
        end
    end

    // EX stage register (p1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            imm_p1      <= '0;
            imm_en_p1   <= 1'b0;
            op_p1       <= '0;
            funct7_p1   <= '0;
            funct3_p1   <= '0;
            rd_addr_p1  <= '0;
            rd_en_p1    <= 1'b0;
            mem_op_p1   <= MEM_NONE;
            jump_en_p1  <= 1'b0;
            rs1_addr_p1 <= '0;
            rs2_addr_p1 <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            cnt         <= '0;
        end else begin
            if (cnt_inc) begin
                cnt <= sat_inc(cnt);
            end
            case (upd)
                UPD_LOAD: begin
                    vld_p1      <= 1'b1;
                    pc_p1       <= id_pc;
                    imm_p1      <= id_imm;
                    imm_en_p1   <= id_imm_en;
                    op_p1       <= id_op;
                    funct7_p1   <= id_funct7;
                    funct3_p1   <= id_funct3;
                    rd_addr_p1  <= id_rd_addr;
                    rd_en_p1    <= id_rd_en;
                    mem_op_p1   <= id_mem_op;
                    jump_en_p1  <= id_jump_en;
                    rs1_addr_p1 <= id_rs1_addr;
                    rs2_addr_p1 <= id_rs2_addr;
                    rs1_data_p1 <= id_rs1_data;
                    rs2_data_p1 <= id_rs2_data;
                end
                UPD_BUBBLE: begin
                    vld_p1      <= 1'b0;
                    pc_p1       <= '0;
                    imm_p1      <= '0;
                    imm_en_p1   <= 1'b0;
                    op_p1       <= '0;
                    funct7_p1   <= '0;
                    funct3_p1   <= '0;
                    rd_addr_p1  <= '0;
                    rd_en_p1    <= 1'b0;
                    mem_op_p1   <= MEM_NONE;
                    jump_en_p1  <= 1'b0;
                    rs1_addr_p1 <= '0;
                    rs2_addr_p1 <= '0;
                    rs1_data_p1 <= '0;
                    rs2_data_p1 <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ex_valid    = vld_p1;
    assign ex_pc       = pc_p1;
    assign ex_imm      = imm_p1;
    assign ex_imm_en   = imm_en_p1;
    assign ex_op       = op_p1;
    assign ex_funct7   = funct7_p1;
    assign ex_funct3   = funct3_p1;
    assign ex_rd_addr  = rd_addr_p1;
    assign ex_rd_en    = rd_en_p1;
    assign ex_mem_op   = mem_op_p1;
    assign ex_jump_en  = jump_en_p1;
    assign ex_rs1_addr = rs1_addr_p1;
    assign ex_rs2_addr = rs2_addr_p1;
    assign ex_rs1_data = rs1_data_p1;
    assign ex_rs2_data = rs2_data_p1;
    assign bubble_cnt  = cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a reference model predicts the EX register, stall and
// bubble counters; a second instance with a 3-bit counter exercises saturation.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        imm_en;
        logic [6:0]  op;
        logic [7:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rd_en;
        logic [4:0]  mem;
        logic        jump;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
    } ex_t;

    typedef struct packed {
        ex_t         ex;
        logic [15:0] cnt;
        logic [2:0]  scnt;
    } exp_t;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [4:0] M_NONE  = 5'b00111;
    localparam logic [4:0] M_LW    = 5'b01010;
    localparam logic [4:0] M_SW    = 5'b10010;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, flush, ex_ready;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic        id_imm_en, id_rd_en, id_jump_en, id_rs1_en, id_rs2_en;
    logic [6:0]  id_op;
    logic [7:0]  id_funct7;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rd_addr, id_mem_op, id_rs1_addr, id_rs2_addr;

    logic        id_stall, ex_valid, ex_imm_en, ex_rd_en, ex_jump_en;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [6:0]  ex_op;
    logic [7:0]  ex_funct7;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd_addr, ex_mem_op, ex_rs1_addr, ex_rs2_addr;
    logic [15:0] bubble_cnt;

    logic        s_id_stall, s_ex_valid, s_ex_imm_en, s_ex_rd_en, s_ex_jump_en;
    logic [31:0] s_ex_pc, s_ex_imm, s_ex_rs1_data, s_ex_rs2_data;
    logic [6:0]  s_ex_op;
    logic [7:0]  s_ex_funct7;
    logic [2:0]  s_ex_funct3;
    logic [4:0]  s_ex_rd_addr, s_ex_mem_op, s_ex_rs1_addr, s_ex_rs2_addr;
    logic [2:0]  s_bubble_cnt;

    ex_t  obs;
    ex_t  m;
    logic [15:0] mcnt;
    logic [2:0]  mscnt;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign obs = {ex_valid, ex_pc, ex_imm, ex_imm_en, ex_op, ex_funct7, ex_funct3, ex_rd_addr,
                  ex_rd_en, ex_mem_op, ex_jump_en, ex_rs1_addr, ex_rs2_addr, ex_rs1_data, ex_rs2_data};

    id_ex_pipe #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush), .ex_ready(ex_ready),
        .id_pc(id_pc), .id_imm(id_imm), .id_imm_en(id_imm_en), .id_op(id_op),
        .id_funct7(id_funct7), .id_funct3(id_funct3), .id_rd_addr(id_rd_addr),
        .id_rd_en(id_rd_en), .id_mem_op(id_mem_op), .id_jump_en(id_jump_en),
        .id_rs1_addr(id_rs1_addr), .id_rs1_en(id_rs1_en), .id_rs2_addr(id_rs2_addr),
        .id_rs2_en(id_rs2_en), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_imm_en(ex_imm_en), .ex_op(ex_op), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
        .ex_rd_addr(ex_rd_addr), .ex_rd_en(ex_rd_en), .ex_mem_op(ex_mem_op),
        .ex_jump_en(ex_jump_en), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe #(.XLEN(32), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush), .ex_ready(ex_ready),
        .id_pc(id_pc), .id_imm(id_imm), .id_imm_en(id_imm_en), .id_op(id_op),
        .id_funct7(id_funct7), .id_funct3(id_funct3), .id_rd_addr(id_rd_addr),
        .id_rd_en(id_rd_en), .id_mem_op(id_mem_op), .id_jump_en(id_jump_en),
        .id_rs1_addr(id_rs1_addr), .id_rs1_en(id_rs1_en), .id_rs2_addr(id_rs2_addr),
        .id_rs2_en(id_rs2_en), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_stall(s_id_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_imm(s_ex_imm),
        .ex_imm_en(s_ex_imm_en), .ex_op(s_ex_op), .ex_funct7(s_ex_funct7),
        .ex_funct3(s_ex_funct3), .ex_rd_addr(s_ex_rd_addr), .ex_rd_en(s_ex_rd_en),
        .ex_mem_op(s_ex_mem_op), .ex_jump_en(s_ex_jump_en), .ex_rs1_addr(s_ex_rs1_addr),
        .ex_rs2_addr(s_ex_rs2_addr), .ex_rs1_data(s_ex_rs1_data),
        .ex_rs2_data(s_ex_rs2_data), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ex_t bubble();
        ex_t b;
        b     = '0;
        b.mem = M_NONE;
        return b;
    endfunction

    function automatic ex_t id_cap();
        ex_t c;
        c.valid  = 1'b1;
        c.pc     = id_pc;
        c.imm    = id_imm;
        c.imm_en = id_imm_en;
        c.op     = id_op;
        c.f7     = id_funct7;
        c.f3     = id_funct3;
        c.rd     = id_rd_addr;
        c.rd_en  = id_rd_en;
        c.mem    = id_mem_op;
        c.jump   = id_jump_en;
        c.rs1    = id_rs1_addr;
        c.rs2    = id_rs2_addr;
        c.d1     = id_rs1_data;
        c.d2     = id_rs2_data;
        return c;
    endfunction

    task automatic set_ins(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                           input logic rd_en, input logic [4:0] mem, input logic [4:0] rs1,
                           input logic rs1_en, input logic [4:0] rs2, input logic rs2_en,
                           input logic [31:0] imm);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_op       = op;
        id_rd_addr  = rd;
        id_rd_en    = rd_en;
        id_mem_op   = mem;
        id_rs1_addr = rs1;
        id_rs1_en   = rs1_en;
        id_rs2_addr = rs2;
        id_rs2_en   = rs2_en;
        id_imm      = imm;
        id_imm_en   = (op != OP_ADD);
        id_funct7   = {1'b0, 7'($urandom_range(0, 127))};
        id_funct3   = 3'($urandom_range(0, 7));
        id_jump_en  = 1'b0;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
    endtask

    // Called at posedge+1 with inputs already applied; predicts, then compares after the edge.
    task automatic step();
        logic hz, st;
        ex_t  nx;
        exp_t e;
        #2;
        hz = m.valid & m.mem[3] & m.rd_en & (m.rd != 5'd0) & id_valid &
             ((id_rs1_en & (id_rs1_addr == m.rd)) | (id_rs2_en & (id_rs2_addr == m.rd)));
        st = ~flush & (hz | ~ex_ready);
        chk("stall", 256'(id_stall), 256'(st));
        chk("stall_sat", 256'(s_id_stall), 256'(st));
        if (flush) nx = bubble();
        else if (!ex_ready) nx = m;
        else if (hz) begin
            nx = bubble();
            if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            if (mscnt != 3'd7) mscnt = mscnt + 3'd1;
        end
        else if (id_valid) nx = id_cap();
        else nx = bubble();
        m      = nx;
        e.ex   = nx;
        e.cnt  = mcnt;
        e.scnt = mscnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 256'(0), 256'(1));
        end else begin
            e = q.pop_front();
            chk("ex", 256'(obs), 256'(e.ex));
            chk("cnt", 256'(bubble_cnt), 256'(e.cnt));
            chk("cnt_sat", 256'(s_bubble_cnt), 256'(e.scnt));
        end
    endtask

    task automatic idle();
        id_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        set_ins(32'h0, OP_ADDI, 5'd0, 1'b0, M_NONE, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        id_valid = 1'b0;
        m = bubble(); mcnt = '0; mscnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex", 256'(obs), 256'(bubble()));
        chk("rst_cnt", 256'(bubble_cnt), 256'(0));
        rst = 1'b0;

        // streaming: ADDI x1,x0,5 ; ADD x2,x1,x1
        set_ins(32'h100, OP_ADDI, 5'd1, 1'b1, M_NONE, 5'd0, 1'b0, 5'd0, 1'b0, 32'd5);
        step();
        chk("stream1_rd", 256'(ex_rd_addr), 256'(1));
        set_ins(32'h104, OP_ADD, 5'd2, 1'b1, M_NONE, 5'd1, 1'b1, 5'd1, 1'b1, 32'd0);
        step();
        chk("stream2_pc", 256'(ex_pc), 256'(32'h104));
        idle(); step();
        chk("stream_cnt", 256'(bubble_cnt), 256'(0));

        // load-use: LW x5,0(x2) ; ADD x6,x5,x7
        set_ins(32'h200, OP_LW, 5'd5, 1'b1, M_LW, 5'd2, 1'b1, 5'd0, 1'b0, 32'd0);
        step();
        set_ins(32'h204, OP_ADD, 5'd6, 1'b1, M_NONE, 5'd5, 1'b1, 5'd7, 1'b1, 32'd0);
        #2 chk("lu_stall", 256'(id_stall), 256'(1));
        step();
        chk("lu_bubble", 256'(ex_valid), 256'(0));
        step();
        chk("lu_add_rd", 256'(ex_rd_addr), 256'(6));
        chk("lu_cnt", 256'(bubble_cnt), 256'(1));
        idle(); step();

        // no false hazard: load to x0, then store followed by use
        set_ins(32'h300, OP_LW, 5'd0, 1'b1, M_LW, 5'd2, 1'b1, 5'd0, 1'b0, 32'd4);
        step();
        set_ins(32'h304, OP_ADD, 5'd1, 1'b1, M_NONE, 5'd0, 1'b1, 5'd0, 1'b1, 32'd0);
        step();
        set_ins(32'h308, OP_SW, 5'd5, 1'b0, M_SW, 5'd2, 1'b1, 5'd5, 1'b1, 32'd8);
        step();
        set_ins(32'h30C, OP_ADD, 5'd6, 1'b1, M_NONE, 5'd5, 1'b1, 5'd5, 1'b1, 32'd0);
        step();
        chk("nofalse_cnt", 256'(bubble_cnt), 256'(1));

        // back-pressure with a pending load-use pair
        set_ins(32'h400, OP_LW, 5'd5, 1'b1, M_LW, 5'd2, 1'b1, 5'd0, 1'b0, 32'd0);
        step();
        set_ins(32'h404, OP_ADD, 5'd6, 1'b1, M_NONE, 5'd5, 1'b1, 5'd5, 1'b1, 32'd0);
        ex_ready = 1'b0;
        repeat (3) step();
        chk("bp_hold_pc", 256'(ex_pc), 256'(32'h400));
        ex_ready = 1'b1;
        step(); step();
        chk("bp_cnt", 256'(bubble_cnt), 256'(2));

        // flush overrides back-pressure and hazard
        set_ins(32'h500, OP_LW, 5'd5, 1'b1, M_LW, 5'd2, 1'b1, 5'd0, 1'b0, 32'd0);
        step();
        set_ins(32'h504, OP_ADD, 5'd6, 1'b1, M_NONE, 5'd5, 1'b1, 5'd5, 1'b1, 32'd0);
        ex_ready = 1'b0; flush = 1'b1;
        step();
        chk("flush_valid", 256'(ex_valid), 256'(0));
        chk("flush_cnt", 256'(bubble_cnt), 256'(2));
        flush = 1'b0; ex_ready = 1'b1;

        // repeated dependent loads: one bubble each; small counter saturates
        set_ins(32'h600, OP_LW, 5'd5, 1'b1, M_LW, 5'd5, 1'b1, 5'd0, 1'b0, 32'd0);
        repeat (20) step();
        chk("sat_small", 256'(s_bubble_cnt), 256'(7));
        chk("sat_big", 256'(bubble_cnt), 256'(12));

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] mo;
            case ($urandom_range(0, 2))
                0: mo = M_LW;
                1: mo = M_SW;
                default: mo = M_NONE;
            endcase
            set_ins(32'($urandom), OP_ADD, 5'($urandom_range(0, 3)), 1'($urandom),
                    mo, 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                    1'($urandom), 32'($urandom));
            id_jump_en = 1'($urandom);
            id_valid   = ($urandom_range(0, 3) != 0);
            ex_ready   = ($urandom_range(0, 4) != 0);
            flush      = ($urandom_range(0, 11) == 0);
            step();
        end
        flush = 1'b0; ex_ready = 1'b1;

        // asynchronous reset mid-run while EX holds a valid instruction
        set_ins(32'h700, OP_ADDI, 5'd3, 1'b1, M_NONE, 5'd1, 1'b1, 5'd0, 1'b0, 32'd7);
        step();
        chk("pre_rst_valid", 256'(ex_valid), 256'(1));
        rst = 1'b1;
        #1;
        chk("arst_valid", 256'(ex_valid), 256'(0));
        chk("arst_mem", 256'(ex_mem_op), 256'(M_NONE));
        chk("arst_cnt", 256'(bubble_cnt), 256'(0));
        chk("arst_cnt_sat", 256'(s_bubble_cnt), 256'(0));
        m = bubble(); mcnt = '0; mscnt = '0;
        q.delete();
        @(posedge clk);
        #1;
        chk("rst_hold", 256'(obs), 256'(bubble()));
        rst = 1'b0;
        step();
        chk("post_rst_pc", 256'(ex_pc), 256'(32'h700));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
